// File: rtl/usr_pkg.sv
// Shared mode encoding and types for the universal shift register.
package usr_pkg;

  typedef logic [2:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD = 3'b000;
  localparam usr_mode_t MODE_SHL  = 3'b001;
  localparam usr_mode_t MODE_SHR  = 3'b010;
  localparam usr_mode_t MODE_ROL  = 3'b011;
  localparam usr_mode_t MODE_ROR  = 3'b100;
  localparam usr_mode_t MODE_LOAD = 3'b101;
  localparam usr_mode_t MODE_CLR  = 3'b110;

  // Shift and rotate modes advance the shift counter; load and clear restart it.
  function automatic logic is_shift_mode(input usr_mode_t mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) ||
           (mode == MODE_ROL) || (mode == MODE_ROR);
  endfunction

endpackage

// File: rtl/usr_next_q.sv
// Combinational next-value mux for the universal shift register.
module usr_next_q
  import usr_pkg::*;
#(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic [WIDTH-1:0] q,
  input  usr_mode_t        mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next
);

  // Select the next register value; reserved encoding falls through to hold.
  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
      MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_LOAD: q_next = din;
      MODE_CLR:  q_next = RST_VAL;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with saturating shift counter and done flag.
// Optional registered parity output is enabled by defining USR_PARITY_EN.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
`ifdef USR_PARITY_EN
  output logic             parity,
`endif
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d, q_next_s;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  usr_mode_t        mode_s;

  assign mode_s = usr_mode_t'(mode);

  usr_next_q #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_next_q (
    .q      (q_q),
    .mode   (mode_s),
    .din    (din),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q_next (q_next_s)
  );

  // Next-state for register, counter and done; done tracks the next counter value.
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    if (en) begin
      q_d = q_next_s;
      if (is_shift_mode(mode_s)) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      end else if ((mode_s == MODE_LOAD) || (mode_s == MODE_CLR)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      q_d   = q_q;
      cnt_d = cnt_q;
    end
    done_d = (cnt_d == CNT_MAX);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifdef USR_PARITY_EN
  logic parity_q;

  // Parity is registered alongside q so it never lags the data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_q <= ^RST_VAL;
    end else begin
      parity_q <= ^q_d;
    end
  end

  assign parity = parity_q;
`endif

  assign q         = q_q;
  assign sout_l    = q_q[WIDTH-1];
  assign sout_r    = q_q[0];
  assign shift_cnt = cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=0) using an expected-value queue.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  typedef struct {
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [W-1:0]  din = 8'h00;
  logic          sin_l = 1'b0;
  logic          sin_r = 1'b0;
  logic [W-1:0]  q;
  logic          sout_l, sout_r, done;
  logic [CW-1:0] shift_cnt;
`ifdef USR_PARITY_EN
  logic          parity;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  exp_t          sb_q[$];
  logic [W-1:0]  m_q = 8'h00;
  logic [CW-1:0] m_cnt = 4'd0;
  logic          m_done = 1'b0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .din       (din),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q         (q),
`ifdef USR_PARITY_EN
    .parity    (parity),
`endif
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of one clock edge; result is queued for the scoreboard.
  task automatic model_edge();
    exp_t e;
    if (!rst) begin
      m_q = 8'h00; m_cnt = 4'd0; m_done = 1'b0;
    end else if (en) begin
      case (mode)
        3'b001: m_q = {m_q[6:0], sin_r};
        3'b010: m_q = {sin_l, m_q[7:1]};
        3'b011: m_q = {m_q[6:0], m_q[7]};
        3'b100: m_q = {m_q[0], m_q[7:1]};
        3'b101: m_q = din;
        3'b110: m_q = 8'h00;
        default: m_q = m_q;
      endcase
      if (mode >= 3'b001 && mode <= 3'b100) begin
        if (m_cnt < 4'd8) m_cnt = m_cnt + 4'd1;
      end else if (mode == 3'b101 || mode == 3'b110) begin
        m_cnt = 4'd0;
      end
      m_done = (m_cnt == 4'd8);
    end
    e.q = m_q; e.cnt = m_cnt; e.done = m_done;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus at the falling edge, then check the DUT after the rising edge.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [W-1:0] d, input logic sl, input logic sr);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; din = d; sin_l = sl; sin_r = sr;
    model_edge();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 64'd1, 64'd0);
    end else begin
      x = sb_q.pop_front();
      check_eq("q", 64'(q), 64'(x.q));
      check_eq("shift_cnt", 64'(shift_cnt), 64'(x.cnt));
      check_eq("done", 64'(done), 64'(x.done));
      check_eq("sout_l", 64'(sout_l), 64'(x.q[7]));
      check_eq("sout_r", 64'(sout_r), 64'(x.q[0]));
`ifdef USR_PARITY_EN
      check_eq("parity", 64'(parity), 64'(^x.q));
`endif
    end
  endtask

  initial begin
    logic [7:0] msb_seq;
    msb_seq = 8'b1010_0101;

    // Reset dominates an active load.
    step(1'b0, 1'b1, 3'b101, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b101, 8'hFF, 1'b0, 1'b0);
    check_eq("rst_q", 64'(q), 64'h00);
    check_eq("rst_done", 64'(done), 64'd0);

    // Load then shift left with ones; sout_l walks the loaded pattern MSB first.
    step(1'b1, 1'b1, 3'b101, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check_eq("shl_sout_l", 64'(sout_l), 64'(msb_seq[7-i]));
      step(1'b1, 1'b1, 3'b001, 8'h00, 1'b0, 1'b1);
    end
    check_eq("shl_end_q", 64'(q), 64'hFF);
    check_eq("shl_end_cnt", 64'(shift_cnt), 64'd8);
    check_eq("shl_end_done", 64'(done), 64'd1);

    // Rotate left past saturation.
    step(1'b1, 1'b1, 3'b101, 8'h81, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0);
      if (i == 1) check_eq("rol1_q", 64'(q), 64'h03);
      if (i == 8) check_eq("rol8_q", 64'(q), 64'h81);
    end
    check_eq("rol10_q", 64'(q), 64'h06);
    check_eq("rol10_cnt", 64'(shift_cnt), 64'd8);
    check_eq("rol10_done", 64'(done), 64'd1);

    // Enable gating, then reserved mode acts as hold.
    step(1'b1, 1'b1, 3'b101, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'b001, 8'h00, 1'b0, 1'b1);
    check_eq("en0_q", 64'(q), 64'h3C);
    check_eq("en0_cnt", 64'(shift_cnt), 64'd0);
    step(1'b1, 1'b1, 3'b111, 8'hFF, 1'b1, 1'b1);
    check_eq("rsvd_q", 64'(q), 64'h3C);

    // Shift right then reset mid-operation.
    step(1'b1, 1'b1, 3'b101, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1);
    check_eq("shr4_q", 64'(q), 64'h05);
    check_eq("shr4_cnt", 64'(shift_cnt), 64'd4);
    step(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b1);
    check_eq("midrst_q", 64'(q), 64'h00);
    check_eq("midrst_cnt", 64'(shift_cnt), 64'd0);

    // Rotate right, reach done, then clear.
    step(1'b1, 1'b1, 3'b101, 8'h01, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    check_eq("ror1_q", 64'(q), 64'h80);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    check_eq("ror8_done", 64'(done), 64'd1);
    step(1'b1, 1'b1, 3'b110, 8'hFF, 1'b0, 1'b0);
    check_eq("clr_q", 64'(q), 64'h00);
    check_eq("clr_cnt", 64'(shift_cnt), 64'd0);
    check_eq("clr_done", 64'(done), 64'd0);

    // Load values with odd and even bit counts.
    step(1'b1, 1'b1, 3'b101, 8'h07, 1'b0, 1'b0);
`ifdef USR_PARITY_EN
    check_eq("par_07", 64'(parity), 64'd1);
`endif
    step(1'b1, 1'b1, 3'b101, 8'h03, 1'b0, 1'b0);
`ifdef USR_PARITY_EN
    check_eq("par_03", 64'(parity), 64'd0);
`endif

    // A few random operations against the model.
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0, ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
